// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler: arbitrates three melody requesters onto one piezo output
// and sequences {runs, halfperiod} note entries into a registered square wave.
module buzzer_scheduler #(
  parameter int                  DEPTH     = 16,
  parameter logic [32*DEPTH-1:0] NOTES     = '0,
  parameter int                  START0    = 0,
  parameter int                  START1    = 4,
  parameter int                  START2    = 8,
  parameter logic [15:0]         REST_HALF = 16'd1000
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       abort,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic       busy,
  output logic       buzz
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] S0 = AW'(START0);
  localparam logic [AW-1:0] S1 = AW'(START1);
  localparam logic [AW-1:0] S2 = AW'(START2);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0] hp_q, hp_d;
  logic [15:0] runs_q, runs_d;
  logic [16:0] cnt_q, cnt_d;
  logic [15:0] rc_q, rc_d;
  logic        buzz_q, buzz_d;

  // Unpack the flat note table into addressable words.
  logic [31:0] table_w [DEPTH];
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unpack
    assign table_w[gi] = NOTES[32*gi +: 32];
  end

  // In PLAY the entry being fetched is the following note so it can start
  // without a gap; elsewhere it is the current address.
  logic [AW-1:0] rd_addr;
  logic [31:0]   ent;
  logic [15:0]   half;
  logic [16:0]   period_last;

  assign rd_addr     = (state_q == PLAY && addr_q != LAST_ADDR) ? addr_q + AW'(1) : addr_q;
  assign ent         = table_w[rd_addr];
  assign half        = (hp_q == 16'd0) ? REST_HALF : hp_q;
  assign period_last = {half, 1'b0} - 17'd1;

  assign busy  = (state_q == LOAD) || (state_q == PLAY);
  assign grant = busy ? owner_q : 3'b000;
  assign done  = (state_q == DONE) ? owner_q : 3'b000;
  assign buzz  = buzz_q;

  // State and datapath registers; reset clears everything without a done pulse.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      addr_q  <= '0;
      hp_q    <= '0;
      runs_q  <= '0;
      cnt_q   <= '0;
      rc_q    <= '0;
      buzz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      hp_q    <= hp_d;
      runs_q  <= runs_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      buzz_q  <= buzz_d;
    end
  end

  // Next-state logic: arbitration, note loading, phase/run counting, abort.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    hp_d    = hp_q;
    runs_d  = runs_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    buzz_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          state_d = LOAD;
          if (req[0]) begin
            owner_d = 3'b001;
            addr_d  = S0;
          end else if (req[1]) begin
            owner_d = 3'b010;
            addr_d  = S1;
          end else begin
            owner_d = 3'b100;
            addr_d  = S2;
          end
        end
      end
      LOAD: begin
        hp_d   = ent[15:0];
        runs_d = ent[31:16];
        cnt_d  = '0;
        rc_d   = '0;
        if (abort || ent[31:16] == 16'd0) state_d = DONE;
        else                              state_d = PLAY;
      end
      PLAY: begin
        buzz_d = (hp_q != 16'd0) && (cnt_q < {1'b0, half});
        if (cnt_q == period_last) begin
          cnt_d = '0;
          rc_d  = rc_q + 16'd1;
          if (rc_q == runs_q - 16'd1) begin
            if (addr_q == LAST_ADDR) begin
              state_d = DONE;
            end else begin
              addr_d = addr_q + AW'(1);
              hp_d   = ent[15:0];
              runs_d = ent[31:16];
              rc_d   = '0;
              if (ent[31:16] == 16'd0) state_d = DONE;
            end
          end
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
        if (abort) begin
          state_d = DONE;
          buzz_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        owner_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Bench for buzzer_scheduler: a schedule-based model expands each granted
// melody into its expected per-cycle outputs; directed steps add literal checks.
module tb_buzzer_scheduler;

  localparam int          DEPTH = 16;
  localparam logic [15:0] REST  = 16'd4;
  // e0={2,3} e1={1,0} e2=term | e4={1,2} e5=term | e14={1,2} e15={1,2}
  localparam logic [32*DEPTH-1:0] TB_NOTES = {
    32'h0001_0002, 32'h0001_0002, {9{32'h0}}, 32'h0001_0002,
    {2{32'h0}}, 32'h0001_0000, 32'h0002_0003};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic       abort = 1'b0;
  logic [2:0] grant, done;
  logic       busy, buzz;

  int checks = 0;
  int errors = 0;

  buzzer_scheduler #(
    .DEPTH(DEPTH), .NOTES(TB_NOTES), .START0(0), .START1(4), .START2(14),
    .REST_HALF(REST)
  ) dut (
    .hwclk(clk), .rst(rst), .req(req), .abort(abort),
    .grant(grant), .done(done), .busy(busy), .buzz(buzz)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct packed {
    logic [2:0] grant;
    logic [2:0] done;
    logic       busy;
    logic       buzz;
  } exp_t;

  exp_t       cur = '0;
  exp_t       sched[$];
  logic [2:0] m_owner = 3'b000;

  function automatic int start_of(input logic [2:0] g);
    if (g == 3'b001) return 0;
    if (g == 3'b010) return 4;
    return 14;
  endfunction

  // Expand a melody into one expected output word per cycle, LOAD to DONE.
  task automatic build(input logic [2:0] g);
    exp_t  e;
    int    addr;
    logic [31:0] w;
    int    runs, hp, h;
    logic  prev_tone;
    prev_tone = 1'b0;
    e = '0; e.grant = g; e.busy = 1'b1;
    sched.push_back(e);
    addr = start_of(g);
    forever begin
      w = TB_NOTES[32*addr +: 32];
      runs = int'(w[31:16]);
      hp   = int'(w[15:0]);
      if (runs == 0) break;
      h = (hp == 0) ? int'(REST) : hp;
      for (int r = 0; r < runs; r++) begin
        for (int c = 0; c < 2*h; c++) begin
          e = '0; e.grant = g; e.busy = 1'b1; e.buzz = prev_tone;
          sched.push_back(e);
          prev_tone = (hp != 0) && (c < h);
        end
      end
      if (addr == DEPTH-1) break;
      addr++;
    end
    e = '0; e.done = g; e.buzz = prev_tone;
    sched.push_back(e);
  endtask

  // Advance the model at every edge; reset clears it immediately.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sched.delete();
      cur = '0;
    end else if (sched.size() != 0) begin
      if (abort && cur.busy) begin
        sched.delete();
        cur = '0;
        cur.done = m_owner;
      end else begin
        cur = sched.pop_front();
      end
    end else if (cur.done != 3'b000) begin
      cur = '0;
    end else if (req != 3'b000) begin
      m_owner = req[0] ? 3'b001 : (req[1] ? 3'b010 : 3'b100);
      build(m_owner);
      cur = sched.pop_front();
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if ({grant, done, busy, buzz} !== cur) begin
      errors++;
      $display("FAIL cycle_model t=%0t actual grant=%b done=%b busy=%b buzz=%b required grant=%b done=%b busy=%b buzz=%b",
               $time, grant, done, busy, buzz, cur.grant, cur.done, cur.busy, cur.buzz);
    end
  end

  // ---------------- directed steps ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == 3'b000 && n < 200);
    if (grant == 3'b000) begin
      errors++;
      $display("FAIL wait_grant timeout actual=0 required=nonzero");
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 3'b000 && n < 200);
    if (done == 3'b000) begin
      errors++;
      $display("FAIL wait_done timeout actual=0 required=nonzero");
    end
  endtask

  initial begin
    logic [19:0] pat;
    int nbusy, ndone;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {24'd0, grant, done, busy, buzz}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Melody 0: tone, rest, terminator
    req = 3'b001;
    @(negedge clk);
    req = 3'b000;
    check("t2_grant_load", {29'd0, grant}, 32'd1);
    nbusy = busy ? 1 : 0;
    ndone = 0;
    @(negedge clk);
    nbusy += busy ? 1 : 0;
    pat = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pat = {pat[18:0], buzz};
      nbusy += busy ? 1 : 0;
      ndone += (done != 3'b000) ? 1 : 0;
    end
    check("t2_buzz_pattern", {12'd0, pat}, {12'd0, 20'b11100011100000000000});
    check("t2_busy_cycles", nbusy, 21);
    check("t2_done_last", {29'd0, done}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      ndone += (done != 3'b000) ? 1 : 0;
    end
    check("t2_done_count", ndone, 1);

    // Asynchronous reset in the middle of PLAY
    req = 3'b001;
    @(negedge clk);
    req = 3'b000;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("t1_async_clear", {24'd0, grant, done, busy, buzz}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      ndone += (done != 3'b000) ? 1 : 0;
    end
    check("t1_no_done_after_reset", ndone, 0);
    check("t1_idle_grant", {29'd0, grant}, 32'd0);

    // Simultaneous requests 1 and 2: priority, then request 2 waits its turn
    req = 3'b110;
    wait_grant();
    check("t3_grant_prio", {29'd0, grant}, 32'd2);
    req = 3'b100;
    wait_done();
    check("t3_done1", {29'd0, done}, 32'd2);
    wait_grant();
    check("t3_grant_next", {29'd0, grant}, 32'd4);
    req = 3'b000;
    wait_done();
    check("t3_done2", {29'd0, done}, 32'd4);

    // No preemption by a higher-priority request
    req = 3'b100;
    wait_grant();
    check("t4_grant2", {29'd0, grant}, 32'd4);
    repeat (2) @(negedge clk);
    req = 3'b101;
    @(negedge clk);
    check("t4_no_preempt", {29'd0, grant}, 32'd4);
    wait_done();
    check("t4_done2", {29'd0, done}, 32'd4);
    req = 3'b001;
    wait_grant();
    check("t4_grant0_after", {29'd0, grant}, 32'd1);
    req = 3'b000;

    // Abort during the 5th PLAY cycle of melody 0
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_abort_done", {29'd0, done}, 32'd1);
    check("t5_abort_buzz", {31'd0, buzz}, 32'd0);
    pat = '0;
    repeat (4) begin
      @(negedge clk);
      pat = {pat[18:0], buzz};
    end
    check("t5_buzz_quiet", {12'd0, pat}, 32'd0);

    // End of table acts as terminator (entries 14, 15)
    req = 3'b100;
    @(negedge clk);
    req = 3'b000;
    check("t6_grant", {29'd0, grant}, 32'd4);
    nbusy = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done != 3'b000) break;
      nbusy += busy ? 1 : 0;
    end
    check("t6_busy_cycles", nbusy, 9);
    check("t6_done", {29'd0, done}, 32'd4);
    repeat (5) @(negedge clk);
    check("t6_idle_after", {24'd0, grant, done, busy, buzz}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
